// File: rtl/main_decoder.sv
// Main control decoder of the 4-bit CPU: opcode -> datapath strobes and ALU-op class,
// registered through one pipeline stage with stall and flush.
module main_decoder (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] op,
    input  logic       op_valid,
    input  logic       stall,
    input  logic       flush,
    output logic       memread,
    output logic       memwrite,
    output logic       branch,
    output logic       alusrc,
    output logic       regdst,
    output logic       regwrite,
    output logic [1:0] aluop,
    output logic       jump,
    output logic       ctrl_valid,
    output logic       illegal
);

    localparam int unsigned OP_W    = 4;
    localparam int unsigned ALUOP_W = 2;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(4'b0000);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(4'b0001);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(4'b1000);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(4'b1010);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4'b1100);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(4'b1110);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(2'b00);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(2'b01);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(2'b10);

    typedef struct packed {
        logic               regwrite;
        logic               regdst;
        logic               alusrc;
        logic               memread;
        logic               memwrite;
        logic               branch;
        logic               jump;
        logic [ALUOP_W-1:0] aluop;
        logic               ctrl_valid;
        logic               illegal;
    } ctrl_t;

    ctrl_t dec_c;
    ctrl_t nxt_c;
    ctrl_t ctrl_q;
    logic  legal_c;

    // Opcode lookup; case equality sends X/Z opcodes to the all-zero default.
    always_comb begin
        dec_c   = '0;
        legal_c = 1'b1;
        case (op)
            OP_RTYPE: begin
                dec_c.regwrite = 1'b1;
                dec_c.regdst   = 1'b1;
                dec_c.aluop    = ALU_FUNCT;
            end
            OP_ADDI: begin
                dec_c.regwrite = 1'b1;
                dec_c.alusrc   = 1'b1;
                dec_c.aluop    = ALU_ADD;
            end
            OP_LW: begin
                dec_c.regwrite = 1'b1;
                dec_c.alusrc   = 1'b1;
                dec_c.memread  = 1'b1;
                dec_c.aluop    = ALU_ADD;
            end
            OP_SW: begin
                dec_c.alusrc   = 1'b1;
                dec_c.memwrite = 1'b1;
                dec_c.aluop    = ALU_ADD;
            end
            OP_BEQ: begin
                dec_c.branch   = 1'b1;
                dec_c.aluop    = ALU_SUB;
            end
            OP_J: begin
                dec_c.jump     = 1'b1;
                dec_c.aluop    = ALU_ADD;
            end
            default: begin
                dec_c   = '0;
                legal_c = 1'b0;
            end
        endcase
    end

    // Qualify the decode with op_valid; invalid slots load a clean bubble.
    always_comb begin
        nxt_c = '0;
        if (op_valid) begin
            nxt_c            = dec_c;
            nxt_c.ctrl_valid = 1'b1;
            nxt_c.illegal    = ~legal_c;
        end
    end

    // Pipeline register: reset > flush > stall > load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrl_q <= '0;
        end else if (flush) begin
            ctrl_q <= '0;
        end else if (!stall) begin
            ctrl_q <= nxt_c;
        end
    end

    assign regwrite   = ctrl_q.regwrite;
    assign regdst     = ctrl_q.regdst;
    assign alusrc     = ctrl_q.alusrc;
    assign memread    = ctrl_q.memread;
    assign memwrite   = ctrl_q.memwrite;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign aluop      = ctrl_q.aluop;
    assign ctrl_valid = ctrl_q.ctrl_valid;
    assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_main_decoder.sv
// Directed bench for main_decoder; outputs packed as
// {rw,rd,as,mr,mw,br,j,aluop[1:0],ctrl_valid,illegal}.
module tb_main_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] op;
    logic       op_valid;
    logic       stall;
    logic       flush;
    logic       memread, memwrite, branch, alusrc, regdst, regwrite, jump;
    logic [1:0] aluop;
    logic       ctrl_valid, illegal;

    int total = 0;
    int bad   = 0;

    localparam logic [10:0] E_ZERO  = 11'b0000000_00_00;
    localparam logic [10:0] E_RTYPE = 11'b1100000_10_10;
    localparam logic [10:0] E_ADDI  = 11'b1010000_00_10;
    localparam logic [10:0] E_LW    = 11'b1011000_00_10;
    localparam logic [10:0] E_SW    = 11'b0010100_00_10;
    localparam logic [10:0] E_BEQ   = 11'b0000010_01_10;
    localparam logic [10:0] E_J     = 11'b0000001_00_10;
    localparam logic [10:0] E_ILL   = 11'b0000000_00_11;

    always #5 clk = ~clk;

    main_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .op_valid   (op_valid),
        .stall      (stall),
        .flush      (flush),
        .memread    (memread),
        .memwrite   (memwrite),
        .branch     (branch),
        .alusrc     (alusrc),
        .regdst     (regdst),
        .regwrite   (regwrite),
        .aluop      (aluop),
        .jump       (jump),
        .ctrl_valid (ctrl_valid),
        .illegal    (illegal)
    );

    // Reference decode for opcodes whose simulated value may not be a clean constant.
    function automatic logic [10:0] ref_exp(input logic [3:0] o, input logic v);
        logic [10:0] e;
        if (!v) return E_ZERO;
        case (o)
            4'b0000: e = E_RTYPE;
            4'b0001: e = E_ADDI;
            4'b1000: e = E_LW;
            4'b1010: e = E_SW;
            4'b1100: e = E_BEQ;
            4'b1110: e = E_J;
            default: e = E_ILL;
        endcase
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [10:0] exp);
        logic [10:0] obs;
        logic [3:0]  onehot;
        obs = {regwrite, regdst, alusrc, memread, memwrite, branch, jump,
               aluop, ctrl_valid, illegal};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
        onehot = {memread, memwrite, branch, jump};
        total++;
        assert ($countones(onehot) <= 1) else begin
            bad++;
            $error("FAIL %s_excl observed=%b expected=at most one set", tag, onehot);
        end
        total++;
        assert (regwrite || !regdst) else begin
            bad++;
            $error("FAIL %s_regdst observed=rw%b rd%b expected=rd 0 when rw 0", tag, regwrite, regdst);
        end
    endtask

    initial begin
        logic [3:0] xop;
        rst_n = 1'b0; op = 4'b1010; op_valid = 1'b1; stall = 1'b0; flush = 1'b0;
        step(); step();
        check("reset", E_ZERO);

        rst_n = 1'b1; op = 4'b0001; op_valid = 1'b1;
        step(); check("addi", E_ADDI);

        op = 4'b0000; step(); check("rtype", E_RTYPE);
        op = 4'b1100; step(); check("beq", E_BEQ);
        op = 4'b1110; step(); check("jump", E_J);
        op = 4'b1010; step(); check("sw", E_SW);

        op = 4'b0011; step(); check("illegal_0011", E_ILL);
        op = 4'bxxxx; xop = op; step(); check("illegal_x", ref_exp(xop, 1'b1));
        op = 4'b0011; op_valid = 1'b0; step(); check("inval_0011", E_ZERO);
        op = 4'bxxxx; step(); check("inval_x", E_ZERO);

        op = 4'b1000; op_valid = 1'b1; step(); check("lw", E_LW);
        op = 4'b1100; stall = 1'b1;
        step(); check("stall1", E_LW);
        step(); check("stall2", E_LW);
        step(); check("stall3", E_LW);
        stall = 1'b0; step(); check("unstall_beq", E_BEQ);

        op = 4'b0000; stall = 1'b1; flush = 1'b1;
        step(); check("flush_over_stall", E_ZERO);
        stall = 1'b0; flush = 1'b0;
        step(); check("reload_rtype", E_RTYPE);
        op = 4'b1000; rst_n = 1'b0; stall = 1'b1;
        step(); check("reset_over_stall", E_ZERO);
        rst_n = 1'b1; stall = 1'b0;
        step(); check("after_reset_lw", E_LW);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
